io_op_sequencer: RTL and testbench

//  Parametrised successor to the G-15 I/O operation control (OC) register logic. Holds the OC code.

---
 rtl/g15_io_pkg.sv | 18 +
 rtl/io_rev_timer.sv | 55 +++++
 rtl/io_op_sequencer.sv | 179 +++++++++++++++++
 tb/tb_io_op_sequencer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/g15_io_pkg.sv
// g15_io_pkg: shared types and constants for the G-15 style I/O operation
// sequencer.
//   io_state_t    - sequencer state: idle, transferring, draining to word time 0
//   DEV_*         - device index carried in the top OC bits
package g15_io_pkg;

    typedef enum logic [1:0] {
        IO_IDLE  = 2'd0,
        IO_RUN   = 2'd1,
        IO_DRAIN = 2'd2
    } io_state_t;

    localparam int DEV_FAST_OUT = 0;
    localparam int DEV_FAST_IN  = 1;
    localparam int DEV_SLOW_OUT = 2;
    localparam int DEV_SLOW_IN  = 3;

endpackage

// File: rtl/io_rev_timer.sv
// io_rev_timer: counts drum revolutions (T0 strobes) that pass without a
// transferred word and flags when the limit is reached.
// Ports:
//   clk_i    in  system clock
//   rst_i    in  synchronous active-high reset
//   clr_i    in  clear the count (new operation or word transferred)
//   en_i     in  count enable (sequencer in RUN)
//   t0_i     in  word-time-0 strobe
//   expire_o out combinational: this T0 is the TIMEOUT_REVS-th empty revolution
// TIMEOUT_REVS = 0 removes the compare; expire_o is then tied low.
module io_rev_timer #(
    parameter int TIMEOUT_REVS = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    input  logic t0_i,
    output logic expire_o
);

    localparam int REV_W = (TIMEOUT_REVS > 1) ? $clog2(TIMEOUT_REVS) : 1;
    // Expiry is detected on the strobe that would make the count reach the
    // limit, so the counter only needs to hold 0..TIMEOUT_REVS-1.
    localparam int LIMIT = (TIMEOUT_REVS == 0) ? 0 : TIMEOUT_REVS - 1;

    logic [REV_W-1:0] cnt_q;
    logic [REV_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && t0_i) begin
            cnt_d = cnt_q + REV_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    generate
        if (TIMEOUT_REVS == 0) begin : g_no_timeout
            assign expire_o = 1'b0;
        end else begin : g_timeout
            assign expire_o = en_i && t0_i && !clr_i && (cnt_q == REV_W'(LIMIT));
        end
    endgenerate

endmodule

// File: rtl/io_op_sequencer.sv
// io_op_sequencer: OC register and I/O operation sequencer.
// Holds the operation code, decodes direction/speed/device, and steps each
// operation IDLE -> RUN -> DRAIN -> IDLE with word counting, block-length
// stop, revolution timeout and abort.
// Ports:
//   CLOCK, rst          clock, synchronous active-high reset
//   T0                  word-time-0 strobe (once per drum revolution)
//   start/start_code    program start pulse and its OC code
//   key_start/key_code  console start pulse and its OC code
//   set_ready, key_stop, pwr_clear   abort sources (any state)
//   word_done           selected device moved one word
//   dev_stop            per-device end mark
//   OC, READY           OC register, idle flag (registered)
//   IN/OUT, FAST/SLOW   direction and speed decode of OC
//   dev_sel             one-hot device select, live only in RUN/DRAIN
//   word_cnt            words moved in the current operation
//   timeout             1-cycle pulse on revolution timeout abort
//   busy_reject         1-cycle pulse when a start arrives while busy
//   dbg_state           current sequencer state (io_state_t encoding)
// Handshake: start/key_start/word_done are single-cycle strobes accepted on
// the clock edge they are high; there is no back-pressure, a start that is
// not accepted is reported through busy_reject.
module io_op_sequencer
    import g15_io_pkg::*;
#(
    parameter  int OC_W         = 4,
    parameter  int DEV_BITS     = 2,
    parameter  int BLOCK_WORDS  = 108,
    parameter  int CNT_W        = 7,
    parameter  int TIMEOUT_REVS = 8,
    localparam int NUM_DEV      = 2 ** DEV_BITS
) (
    input  logic               CLOCK,
    input  logic               rst,
    input  logic               T0,
    input  logic               start,
    input  logic [OC_W-1:0]    start_code,
    input  logic               key_start,
    input  logic [OC_W-1:0]    key_code,
    input  logic               set_ready,
    input  logic               key_stop,
    input  logic               pwr_clear,
    input  logic               word_done,
    input  logic [NUM_DEV-1:0] dev_stop,
    output logic [OC_W-1:0]    OC,
    output logic               READY,
    output logic               IN,
    output logic               OUT,
    output logic               FAST,
    output logic               SLOW,
    output logic [NUM_DEV-1:0] dev_sel,
    output logic [CNT_W-1:0]   word_cnt,
    output logic               timeout,
    output logic               busy_reject,
    output logic [1:0]         dbg_state
);

    io_state_t           state_q;
    logic [OC_W-1:0]     oc_q;
    logic [CNT_W-1:0]    word_cnt_q;
    logic                ready_q;
    logic                timeout_q;
    logic                busy_reject_q;

    logic                abort;
    logic                req;
    logic [OC_W-1:0]     req_code;
    logic                load;
    logic [DEV_BITS-1:0] dev_idx;
    logic                sel_stop;
    logic                last_word;
    logic                expire;

    assign abort     = set_ready | key_stop | pwr_clear;
    assign req       = start | key_start;
    assign req_code  = start ? start_code : key_code;
    assign load      = (state_q == IO_IDLE) && req && (req_code != '0) && !abort;
    assign dev_idx   = oc_q[OC_W-1 -: DEV_BITS];
    assign sel_stop  = dev_stop[dev_idx];
    assign last_word = (word_cnt_q == CNT_W'(BLOCK_WORDS - 1));

    io_rev_timer #(
        .TIMEOUT_REVS(TIMEOUT_REVS)
    ) u_rev_timer (
        .clk_i   (CLOCK),
        .rst_i   (rst),
        .clr_i   (abort | load | ((state_q == IO_RUN) && word_done)),
        .en_i    (state_q == IO_RUN),
        .t0_i    (T0),
        .expire_o(expire)
    );

    always_ff @(posedge CLOCK) begin
        if (rst) begin
            state_q       <= IO_IDLE;
            oc_q          <= '0;
            word_cnt_q    <= '0;
            ready_q       <= 1'b1;
            timeout_q     <= 1'b0;
            busy_reject_q <= 1'b0;
        end else if (abort) begin
            state_q       <= IO_IDLE;
            oc_q          <= '0;
            word_cnt_q    <= '0;
            ready_q       <= 1'b1;
            timeout_q     <= 1'b0;
            busy_reject_q <= 1'b0;
        end else begin
            timeout_q     <= 1'b0;
            busy_reject_q <= 1'b0;
            case (state_q)
                IO_IDLE: begin
                    if (load) begin
                        oc_q       <= req_code;
                        word_cnt_q <= '0;
                        state_q    <= IO_RUN;
                        ready_q    <= 1'b0;
                    end
                end
                IO_RUN: begin
                    busy_reject_q <= req;
                    if (word_done) begin
                        // The final word of a block is not counted past
                        // BLOCK_WORDS-1; it only ends the transfer.
                        if (last_word) begin
                            state_q <= IO_DRAIN;
                        end else begin
                            word_cnt_q <= word_cnt_q + CNT_W'(1);
                        end
                        if (sel_stop) begin
                            state_q <= IO_DRAIN;
                        end
                    end else if (sel_stop) begin
                        state_q <= IO_DRAIN;
                    end else if (expire) begin
                        timeout_q <= 1'b1;
                        oc_q      <= '0;
                        state_q   <= IO_IDLE;
                        ready_q   <= 1'b1;
                    end
                end
                IO_DRAIN: begin
                    busy_reject_q <= req;
                    // Any T0 seen while in DRAIN is at least one cycle after
                    // entry, so a strobe coinciding with the entry edge is skipped.
                    if (T0) begin
                        oc_q    <= '0;
                        state_q <= IO_IDLE;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    oc_q    <= '0;
                    state_q <= IO_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        dev_sel = '0;
        if (state_q == IO_RUN || state_q == IO_DRAIN) begin
            dev_sel = NUM_DEV'(1) << dev_idx;
        end
    end

    assign OC          = oc_q;
    assign READY       = ready_q;
    assign IN          = oc_q[OC_W-2];
    assign OUT         = ~oc_q[OC_W-2];
    assign SLOW        = oc_q[OC_W-1];
    assign FAST        = ~oc_q[OC_W-1];
    assign word_cnt    = word_cnt_q;
    assign timeout     = timeout_q;
    assign busy_reject = busy_reject_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_io_op_sequencer.sv
// tb_io_op_sequencer: directed bench for io_op_sequencer.
// Three instances share one stimulus stream:
//   dut_a - default parameters
//   dut_b - BLOCK_WORDS = 4 (block-length stop)
//   dut_c - TIMEOUT_REVS = 0 (timeout disabled)
module tb_io_op_sequencer;
    import g15_io_pkg::*;

    logic       CLOCK;
    logic       rst;
    logic       T0;
    logic       start;
    logic [3:0] start_code;
    logic       key_start;
    logic [3:0] key_code;
    logic       set_ready;
    logic       key_stop;
    logic       pwr_clear;
    logic       word_done;
    logic [3:0] dev_stop;

    logic [3:0] a_oc, b_oc, c_oc;
    logic       a_ready, b_ready, c_ready;
    logic       a_in, b_in, c_in;
    logic       a_out, b_out, c_out;
    logic       a_fast, b_fast, c_fast;
    logic       a_slow, b_slow, c_slow;
    logic [3:0] a_sel, b_sel, c_sel;
    logic [6:0] a_cnt, b_cnt, c_cnt;
    logic       a_to, b_to, c_to;
    logic       a_br, b_br, c_br;
    logic [1:0] a_st, b_st, c_st;

    int n_total = 0;
    int n_bad   = 0;
    logic c_to_seen;

    io_op_sequencer dut_a (
        .CLOCK(CLOCK), .rst(rst), .T0(T0), .start(start), .start_code(start_code),
        .key_start(key_start), .key_code(key_code), .set_ready(set_ready),
        .key_stop(key_stop), .pwr_clear(pwr_clear), .word_done(word_done),
        .dev_stop(dev_stop), .OC(a_oc), .READY(a_ready), .IN(a_in), .OUT(a_out),
        .FAST(a_fast), .SLOW(a_slow), .dev_sel(a_sel), .word_cnt(a_cnt),
        .timeout(a_to), .busy_reject(a_br), .dbg_state(a_st)
    );

    io_op_sequencer #(.BLOCK_WORDS(4)) dut_b (
        .CLOCK(CLOCK), .rst(rst), .T0(T0), .start(start), .start_code(start_code),
        .key_start(key_start), .key_code(key_code), .set_ready(set_ready),
        .key_stop(key_stop), .pwr_clear(pwr_clear), .word_done(word_done),
        .dev_stop(dev_stop), .OC(b_oc), .READY(b_ready), .IN(b_in), .OUT(b_out),
        .FAST(b_fast), .SLOW(b_slow), .dev_sel(b_sel), .word_cnt(b_cnt),
        .timeout(b_to), .busy_reject(b_br), .dbg_state(b_st)
    );

    io_op_sequencer #(.TIMEOUT_REVS(0)) dut_c (
        .CLOCK(CLOCK), .rst(rst), .T0(T0), .start(start), .start_code(start_code),
        .key_start(key_start), .key_code(key_code), .set_ready(set_ready),
        .key_stop(key_stop), .pwr_clear(pwr_clear), .word_done(word_done),
        .dev_stop(dev_stop), .OC(c_oc), .READY(c_ready), .IN(c_in), .OUT(c_out),
        .FAST(c_fast), .SLOW(c_slow), .dev_sel(c_sel), .word_cnt(c_cnt),
        .timeout(c_to), .busy_reject(c_br), .dbg_state(c_st)
    );

    // Clock and overall time limit.
    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got=running exp=finished");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs set after this return are seen on the next edge.
    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic do_start(input logic [3:0] code);
        start = 1'b1; start_code = code;
        tick();
        start = 1'b0; start_code = '0;
    endtask

    task automatic do_word();
        word_done = 1'b1;
        tick();
        word_done = 1'b0;
        tick();
    endtask

    task automatic do_t0();
        T0 = 1'b1;
        tick();
        T0 = 1'b0;
    endtask

    task automatic do_abort();
        key_stop = 1'b1;
        tick();
        key_stop = 1'b0;
    endtask

    initial begin
        rst = 1'b1; T0 = 1'b0; start = 1'b0; start_code = '0;
        key_start = 1'b0; key_code = '0; set_ready = 1'b0; key_stop = 1'b0;
        pwr_clear = 1'b0; word_done = 1'b0; dev_stop = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_oc",    32'(a_oc), 32'h0);
        check("rst_ready", 32'(a_ready), 32'h1);
        check("rst_cnt",   32'(a_cnt), 32'h0);
        check("rst_sel",   32'(a_sel), 32'h0);
        check("rst_to",    32'(a_to), 32'h0);
        check("rst_br",    32'(a_br), 32'h0);
        check("rst_state", 32'(a_st), 32'(IO_IDLE));

        // 1: slow-in operation, three words, device stop, drain to T0
        do_start(4'b1100);
        check("t1_ready",  32'(a_ready), 32'h0);
        check("t1_oc",     32'(a_oc), 32'hC);
        check("t1_slow",   32'(a_slow), 32'h1);
        check("t1_in",     32'(a_in), 32'h1);
        check("t1_sel",    32'(a_sel), 32'h8);
        for (int i = 0; i < 3; i++) do_word();
        check("t1_cnt",    32'(a_cnt), 32'h3);
        dev_stop = 4'b0001;
        tick();
        dev_stop = '0;
        check("t1_unsel_stop", 32'(a_st), 32'(IO_RUN));
        dev_stop = 4'b1000;
        tick();
        dev_stop = '0;
        check("t1_drain",  32'(a_st), 32'(IO_DRAIN));
        tick();
        check("t1_drain_hold", 32'(a_oc), 32'hC);
        check("t1_drain_busy", 32'(a_ready), 32'h0);
        do_t0();
        check("t1_idle_oc",    32'(a_oc), 32'h0);
        check("t1_idle_ready", 32'(a_ready), 32'h1);
        check("t1_idle_cnt",   32'(a_cnt), 32'h3);
        check("t1_idle_sel",   32'(a_sel), 32'h0);

        // 2: block-length stop on dut_b (4 words)
        do_start(4'b0100);
        check("t2_sel",    32'(b_sel), 32'h2);
        check("t2_fast",   32'(b_fast), 32'h1);
        for (int i = 0; i < 3; i++) do_word();
        check("t2_cnt3",   32'(b_cnt), 32'h3);
        check("t2_run3",   32'(b_st), 32'(IO_RUN));
        do_word();
        check("t2_drain",  32'(b_st), 32'(IO_DRAIN));
        check("t2_cnt4",   32'(b_cnt), 32'h3);
        check("t2_a_cnt4", 32'(a_cnt), 32'h4);
        do_word();
        check("t2_cnt5",   32'(b_cnt), 32'h3);
        do_t0();
        check("t2_idle",   32'(b_ready), 32'h1);
        do_abort();
        check("t2_abort_cnt", 32'(a_cnt), 32'h0);

        // 3: revolution timeout on dut_a, disabled on dut_c
        do_start(4'b1000);
        check("t3_out",    32'(a_out), 32'h1);
        check("t3_sel",    32'(a_sel), 32'h4);
        c_to_seen = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            do_t0();
            c_to_seen = c_to_seen | c_to;
            if (i == 7) check("t3_to_early", 32'(a_to), 32'h0);
            if (i == 8) begin
                check("t3_to_pulse", 32'(a_to), 32'h1);
                check("t3_to_oc",    32'(a_oc), 32'h0);
                check("t3_to_ready", 32'(a_ready), 32'h1);
            end
            tick();
            c_to_seen = c_to_seen | c_to;
            if (i == 8) check("t3_to_clear", 32'(a_to), 32'h0);
        end
        check("t3_c_no_to",  32'(c_to_seen), 32'h0);
        check("t3_c_run",    32'(c_st), 32'(IO_RUN));
        do_abort();

        // 4: abort beats word_done and the timeout T0 in the same cycle
        do_start(4'b1000);
        do_word();
        check("t4_cnt1", 32'(a_cnt), 32'h1);
        for (int i = 0; i < 7; i++) begin
            do_t0();
            tick();
        end
        check("t4_still_run", 32'(a_st), 32'(IO_RUN));
        key_stop = 1'b1; word_done = 1'b1; T0 = 1'b1;
        tick();
        key_stop = 1'b0; word_done = 1'b0; T0 = 1'b0;
        check("t4_ready", 32'(a_ready), 32'h1);
        check("t4_cnt0",  32'(a_cnt), 32'h0);
        check("t4_oc",    32'(a_oc), 32'h0);
        check("t4_to",    32'(a_to), 32'h0);
        tick();
        check("t4_to2",   32'(a_to), 32'h0);

        // 5: start priority, busy reject, zero code
        start = 1'b1; start_code = 4'b1100; key_start = 1'b1; key_code = 4'b0100;
        tick();
        start = 1'b0; start_code = '0; key_start = 1'b0; key_code = '0;
        check("t5_prio_oc", 32'(a_oc), 32'hC);
        do_start(4'b0100);
        check("t5_br",      32'(a_br), 32'h1);
        check("t5_br_oc",   32'(a_oc), 32'hC);
        tick();
        check("t5_br_off",  32'(a_br), 32'h0);
        do_abort();
        do_start(4'b0000);
        check("t5_zero_ready", 32'(a_ready), 32'h1);
        check("t5_zero_state", 32'(a_st), 32'(IO_IDLE));
        key_start = 1'b1; key_code = 4'b0101;
        tick();
        key_start = 1'b0; key_code = '0;
        check("t5_key_oc",  32'(a_oc), 32'h5);
        pwr_clear = 1'b1;
        tick();
        pwr_clear = 1'b0;
        check("t5_pwr_clr", 32'(a_oc), 32'h0);

        // 6: reset mid-RUN alongside word_done
        do_start(4'b0100);
        do_word();
        rst = 1'b1; word_done = 1'b1;
        tick();
        rst = 1'b0; word_done = 1'b0;
        check("t6_oc",    32'(a_oc), 32'h0);
        check("t6_ready", 32'(a_ready), 32'h1);
        check("t6_cnt",   32'(a_cnt), 32'h0);
        check("t6_sel",   32'(a_sel), 32'h0);
        check("t6_to",    32'(a_to), 32'h0);
        check("t6_br",    32'(a_br), 32'h0);
        check("t6_dir",   32'({a_in, a_out, a_fast, a_slow}), 32'b0110);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
